// File: rtl/mem_controller.sv
// Memory-access sequencer: one bus transaction per FETCH/MEM control state, with byte lanes.
// Optional bus timeout: define MEM_TIMEOUT_EN (abort after TIMEOUT_CYCLES unacked REQ cycles).
module mem_controller #(
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter int unsigned CONTROL_BIT_MAX = 7,
    parameter logic [CONTROL_BIT_MAX:0] STATE_FETCH = (CONTROL_BIT_MAX+1)'(2),
    parameter logic [CONTROL_BIT_MAX:0] STATE_MEM   = (CONTROL_BIT_MAX+1)'(16)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [CONTROL_BIT_MAX:0] control_i,
    input  logic [15:0]              pc,
    input  logic [15:0]              addr,
    input  logic [15:0]              wdata,
    input  logic                     mem_we,
    input  logic                     mem_byte,
    output logic                     mem_wait,
    output logic [15:0]              instr_o,
    output logic [15:0]              data_o,
    output logic                     bus_req,
    output logic                     bus_we,
    output logic [14:0]              bus_addr,
    output logic [1:0]               bus_be,
    output logic [15:0]              bus_wdata,
    input  logic [15:0]              bus_rdata,
    input  logic                     bus_ack,
    output logic                     bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        fetch_q, fetch_d;
    logic [14:0] addr_q, addr_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] data_q, data_d;
    logic        is_fetch_c, is_mem_c;
    logic        unused_pc0;

    assign unused_pc0 = pc[0];
    assign is_fetch_c = (control_i == STATE_FETCH);
    assign is_mem_c   = (control_i == STATE_MEM);
    assign mem_wait   = (is_fetch_c || is_mem_c) && (state_q != S_DONE);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        fetch_d = fetch_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        data_d  = data_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en && (is_fetch_c || is_mem_c)) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    fetch_d = is_fetch_c;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                    if (is_fetch_c) begin
                        addr_d = pc[15:1];
                        we_d   = 1'b0;
                        be_d   = 2'b11;
                    end else begin
                        addr_d  = addr[15:1];
                        we_d    = mem_we;
                        be_d    = mem_byte ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
                        wdata_d = mem_byte ? {wdata[7:0], wdata[7:0]} : wdata;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (fetch_q) begin
                        instr_d = bus_rdata;
                    end else if (!we_q) begin
                        // Byte loads zero-extend the lane selected by the latched enable
                        case (be_q)
                            2'b10:   data_d = {8'h00, bus_rdata[15:8]};
                            2'b01:   data_d = {8'h00, bus_rdata[7:0]};
                            default: data_d = bus_rdata;
                        endcase
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (fetch_q) begin
                        instr_d = 16'hFFFF;
                    end else if (!we_q) begin
                        data_d = 16'hFFFF;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_DONE: begin
                if (en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            addr_q  <= 15'd0;
            be_q    <= 2'b00;
            wdata_q <= 16'd0;
            instr_q <= 16'd0;
            data_q  <= 16'd0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            fetch_q <= fetch_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            data_q  <= data_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign instr_o   = instr_q;
    assign data_o    = data_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err   = err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed scenarios plus random transactions against a memory model.
module tb_mem_controller;

    localparam logic [7:0] C_FETCH = 8'h02;
    localparam logic [7:0] C_MEM   = 8'h10;
    localparam logic [7:0] C_NOP   = 8'h01;
`ifdef MEM_TIMEOUT_EN
    localparam int KMAX = 3;
`else
    localparam int KMAX = 5;
`endif

    logic        clk = 1'b0;
    logic        rst, en, mem_we, mem_byte, bus_ack;
    logic [7:0]  control_i;
    logic [15:0] pc, addr, wdata, bus_rdata;
    logic        mem_wait, bus_req, bus_we, bus_err;
    logic [15:0] instr_o, data_o, bus_wdata;
    logic [14:0] bus_addr;
    logic [1:0]  bus_be;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [logic [14:0]];
    logic [15:0] exp_instr, exp_data;
    logic        exp_err;

    mem_controller #(
        .TIMEOUT_CYCLES (4),
        .CONTROL_BIT_MAX(7),
        .STATE_FETCH    (C_FETCH),
        .STATE_MEM      (C_MEM)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .control_i(control_i),
        .pc(pc), .addr(addr), .wdata(wdata), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_wait(mem_wait), .instr_o(instr_o), .data_o(data_o),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [14:0] w);
        if (mem.exists(w)) return mem[w];
        return 16'({1'b0, w}) ^ 16'h5A5A;
    endfunction

    task automatic chk_outputs_done();
        chk("done_req", 16'(bus_req), 16'd0);
        chk("done_wait", 16'(mem_wait), 16'd0);
        chk("instr", instr_o, exp_instr);
        chk("data", data_o, exp_data);
        chk("err", 16'(bus_err), 16'(exp_err));
    endtask

    // kind: 0 fetch, 1 load, 2 store. Ack arrives in REQ cycle k (0-based).
    task automatic access(input int kind, input logic [15:0] a, input logic [15:0] wd,
                          input logic byt, input int k, input int done_hold,
                          input bit en_drop, output int req_cycles);
        logic [15:0] rd, exp_wd, w;
        logic [1:0]  exp_be;
        req_cycles = 0;
        @(negedge clk);
        en = 1'b1;
        pc = $urandom; addr = $urandom; wdata = $urandom;
        mem_we = 1'($urandom); mem_byte = 1'($urandom);
        if (kind == 0) begin
            control_i = C_FETCH; pc = a;
        end else begin
            control_i = C_MEM; addr = a; wdata = wd;
            mem_we = (kind == 2); mem_byte = byt;
        end
        #1 chk("idle_wait", 16'(mem_wait), 16'd1);
        exp_be = (kind == 0 || !byt) ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
        exp_wd = byt ? {wd[7:0], wd[7:0]} : wd;
        rd = 16'd0;
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            if (bus_req) req_cycles++;
            chk("req", 16'(bus_req), 16'd1);
            chk("req_wait", 16'(mem_wait), 16'd1);
            chk("addr", 16'(bus_addr), 16'(a[15:1]));
            chk("be", 16'(bus_be), 16'(exp_be));
            chk("we", 16'(bus_we), 16'(kind == 2));
            if (kind != 0) chk("wdata", bus_wdata, exp_wd);
            pc = $urandom; addr = $urandom; wdata = $urandom;
            if (en_drop) en = 1'b0;
            if (i == k) begin
                bus_ack = 1'b1;
                rd = (kind == 2) ? 16'($urandom) : mem_rd(a[15:1]);
                bus_rdata = rd;
            end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        if (kind == 0) begin
            exp_instr = rd;
        end else if (kind == 1) begin
            exp_data = !byt ? rd : (a[0] ? {8'h00, rd[15:8]} : {8'h00, rd[7:0]});
        end else begin
            w = mem_rd(a[15:1]);
            if (exp_be[1]) w[15:8] = exp_wd[15:8];
            if (exp_be[0]) w[7:0]  = exp_wd[7:0];
            mem[a[15:1]] = w;
        end
        chk_outputs_done();
        en = 1'b0;
        for (int h = 0; h < done_hold; h++) begin
            bus_ack = 1'($urandom);
            @(negedge clk);
            chk_outputs_done();
        end
        bus_ack = 1'b0;
        en = 1'b1;
        control_i = C_NOP;
    endtask

    initial begin
        int rc;
        rst = 1'b1; en = 1'b0; control_i = C_NOP;
        pc = 16'd0; addr = 16'd0; wdata = 16'd0; mem_we = 1'b0; mem_byte = 1'b0;
        bus_ack = 1'b0; bus_rdata = 16'd0;
        exp_instr = 16'd0; exp_data = 16'd0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 16'(bus_req), 16'd0);
        chk("rst_we", 16'(bus_we), 16'd0);
        chk("rst_err", 16'(bus_err), 16'd0);
        chk("rst_addr", 16'(bus_addr), 16'd0);
        chk("rst_be", 16'(bus_be), 16'd0);
        chk("rst_wdata", bus_wdata, 16'd0);
        chk("rst_instr", instr_o, 16'd0);
        chk("rst_data", data_o, 16'd0);
        rst = 1'b0;

        // Non-memory control states start nothing
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            control_i = 8'h01 << (i * 3);
            bus_ack = 1'b1;
            #1 chk("nop_wait", 16'(mem_wait), 16'd0);
            @(negedge clk);
            chk("nop_req", 16'(bus_req), 16'd0);
        end
        bus_ack = 1'b0;
        control_i = C_NOP;

        mem[15'h0081] = 16'hA5C3;
        access(0, 16'h0102, 16'h0000, 1'b0, 0, 0, 1'b0, rc);
        chk("fetch_k0_reqcyc", 16'(rc), 16'd1);
        chk("fetch_k0_instr", instr_o, 16'hA5C3);
        access(0, 16'h0203, 16'h0000, 1'b0, 3, 0, 1'b0, rc);
        chk("fetch_k3_reqcyc", 16'(rc), 16'd4);
        mem[15'h0008] = 16'hBEEF;
        access(1, 16'h0011, 16'h0000, 1'b1, 1, 0, 1'b0, rc);
        chk("byte_load", data_o, 16'h00BE);
        chk("byte_load_instr", instr_o, exp_instr);
        access(2, 16'h0010, 16'h1234, 1'b1, 0, 1, 1'b0, rc);
        chk("byte_store_data", data_o, 16'h00BE);
        access(1, 16'h0011, 16'h0000, 1'b0, 2, 2, 1'b1, rc);
        chk("word_load_after_store", data_o, 16'hBE34);

        // Reset in the middle of a request; a late ack must not capture
        @(negedge clk);
        control_i = C_FETCH; pc = 16'h0400; en = 1'b1;
        @(negedge clk);
        chk("mid_req", 16'(bus_req), 16'd1);
        #2 rst = 1'b1;
        #1 chk("async_drop", 16'(bus_req), 16'd0);
        control_i = C_NOP;
        #1 rst = 1'b0;
        exp_instr = 16'd0; exp_data = 16'd0; exp_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 16'hDEAD;
        @(negedge clk);
        bus_ack = 1'b0;
        chk_outputs_done();

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            access(kind, 16'($urandom_range(0, 63)), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, KMAX)), int'($urandom_range(0, 2)),
                   ($urandom_range(0, 3) == 0), rc);
        end

`ifdef MEM_TIMEOUT_EN
        // Load with no ack aborts after four REQ cycles
        @(negedge clk);
        control_i = C_MEM; addr = 16'h0022; mem_we = 1'b0; mem_byte = 1'b1; en = 1'b1;
        rc = 0;
        for (int i = 0; i < 8 && (i == 0 || bus_req); i++) begin
            @(negedge clk);
            if (bus_req) rc++;
        end
        chk("timeout_reqcyc", 16'(rc), 16'd4);
        exp_data = 16'hFFFF; exp_err = 1'b1;
        chk_outputs_done();
        control_i = C_NOP;
        access(0, 16'h0030, 16'h0000, 1'b0, 1, 0, 1'b0, rc);
        chk("err_sticky", 16'(bus_err), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("err_cleared", 16'(bus_err), 16'd0);
        rst = 1'b0;
        exp_instr = 16'd0; exp_data = 16'd0; exp_err = 1'b0;
`else
        chk("err_tied", 16'(bus_err), 16'd0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
